// File: rtl/writeback_regfile_if.sv
// writeback_regfile_if
// Bundles the writeback stage's input controls/data and its registered outputs.
//   master : drives enable_writeback, W_Control, aluout, memout, pcout, dr, sr;
//            observes vsr, psr, wb_valid
//   slave  : the writeback_regfile side (inverse directions)
// Parameters must match those of the writeback_regfile instance attached to it.
interface writeback_regfile_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int NUM_RD   = 2
);
    localparam int REG_AW = $clog2(NUM_REGS);

    logic                       enable_writeback;
    logic [1:0]                 W_Control;
    logic [DATA_W-1:0]          aluout;
    logic [DATA_W-1:0]          memout;
    logic [DATA_W-1:0]          pcout;
    logic [REG_AW-1:0]          dr;
    logic [NUM_RD*REG_AW-1:0]   sr;
    logic [NUM_RD*DATA_W-1:0]   vsr;
    logic [2:0]                 psr;
    logic                       wb_valid;

    modport master (
        output enable_writeback, W_Control, aluout, memout, pcout, dr, sr,
        input  vsr, psr, wb_valid
    );

    modport slave (
        input  enable_writeback, W_Control, aluout, memout, pcout, dr, sr,
        output vsr, psr, wb_valid
    );
endinterface

// File: rtl/writeback_regfile.sv
// writeback_regfile
// LC3 writeback stage: picks the result source, commits it into the register
// file, updates the N/Z/P condition code and returns registered operand reads.
//   clock  : rising-edge clock
//   reset  : asynchronous, active-high; clears RF, vsr, psr, wb_valid
//   wb     : writeback_regfile_if.slave
//            enable_writeback, W_Control (0 alu, 1 mem, 2 pc, 3 no-write),
//            aluout/memout/pcout, dr, packed sr in; packed vsr, psr, wb_valid out
// Optional feature: define WRITEBACK_REGFILE_FWD_EN to forward the committed
// value to any read port addressing dr on the same edge. Without it, such a
// read returns the pre-write contents.
module writeback_regfile #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int NUM_RD   = 2
) (
    input  logic                clock,
    input  logic                reset,
    writeback_regfile_if.slave  wb
);
    localparam int REG_AW = $clog2(NUM_REGS);

    logic [DATA_W-1:0]        rf_q [NUM_REGS];
    logic [DATA_W-1:0]        rf_d [NUM_REGS];
    logic [NUM_RD*DATA_W-1:0] vsr_q, vsr_d;
    logic [2:0]               psr_q, psr_d;
    logic                     wb_valid_q, wb_valid_d;

    logic [DATA_W-1:0]        sel;
    logic                     commit;

    always_comb begin
        sel = '0;
        case (wb.W_Control)
            2'd0:    sel = wb.aluout;
            2'd1:    sel = wb.memout;
            2'd2:    sel = wb.pcout;
            default: sel = '0;
        endcase
    end

    assign commit = wb.enable_writeback && (wb.W_Control != 2'd3);

    always_comb begin
        rf_d       = rf_q;
        psr_d      = psr_q;
        wb_valid_d = commit;
        if (commit) begin
            rf_d[wb.dr] = sel;
            if (sel[DATA_W-1])
                psr_d = 3'b100;
            else if (sel == '0)
                psr_d = 3'b010;
            else
                psr_d = 3'b001;
        end
    end

    // Reads sample the current RF every edge, regardless of enable_writeback.
    always_comb begin
        vsr_d = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            vsr_d[i*DATA_W +: DATA_W] = rf_q[wb.sr[i*REG_AW +: REG_AW]];
`ifdef WRITEBACK_REGFILE_FWD_EN
            if (commit && (wb.sr[i*REG_AW +: REG_AW] == wb.dr))
                vsr_d[i*DATA_W +: DATA_W] = sel;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                rf_q[i] <= '0;
            vsr_q      <= '0;
            psr_q      <= 3'b000;
            wb_valid_q <= 1'b0;
        end else begin
            rf_q       <= rf_d;
            vsr_q      <= vsr_d;
            psr_q      <= psr_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    assign wb.vsr      = vsr_q;
    assign wb.psr      = psr_q;
    assign wb.wb_valid = wb_valid_q;
endmodule
